// File: rtl/dmux4way16_buf_if.sv
// Bundle of the upstream push port and the four downstream channel ports of
// dmux4way16_buf. master = the side that drives words in and consumes them
// (environment); slave = the demux itself.
//
// Ports:
//   entrada_valid/entrada_dado/entrada_sel/entrada_ready : upstream push handshake
//   saida_valid_X/saida_dado_X/saida_ready_X (X=a..d)    : per-channel pop handshake
//   contador_total                                       : accepted-word counter
interface dmux4way16_buf_if;
  logic        entrada_valid;
  logic [15:0] entrada_dado;
  logic [1:0]  entrada_sel;
  logic        entrada_ready;

  logic        saida_valid_a;
  logic        saida_valid_b;
  logic        saida_valid_c;
  logic        saida_valid_d;
  logic [15:0] saida_dado_a;
  logic [15:0] saida_dado_b;
  logic [15:0] saida_dado_c;
  logic [15:0] saida_dado_d;
  logic        saida_ready_a;
  logic        saida_ready_b;
  logic        saida_ready_c;
  logic        saida_ready_d;

  logic [15:0] contador_total;

  modport master (
    output entrada_valid, entrada_dado, entrada_sel,
    output saida_ready_a, saida_ready_b, saida_ready_c, saida_ready_d,
    input  entrada_ready,
    input  saida_valid_a, saida_valid_b, saida_valid_c, saida_valid_d,
    input  saida_dado_a, saida_dado_b, saida_dado_c, saida_dado_d,
    input  contador_total
  );

  modport slave (
    input  entrada_valid, entrada_dado, entrada_sel,
    input  saida_ready_a, saida_ready_b, saida_ready_c, saida_ready_d,
    output entrada_ready,
    output saida_valid_a, saida_valid_b, saida_valid_c, saida_valid_d,
    output saida_dado_a, saida_dado_b, saida_dado_c, saida_dado_d,
    output contador_total
  );
endinterface

// File: rtl/dmux4way16_buf.sv
// Purpose: 2-entry, 16-bit FIFO used once per demux output channel.
// Latency: word written at edge N is visible at dat_o/vld_o right after edge N.
// Backpressure: full_o high at occupancy 2; a push while full is dropped even if popping.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset (clears pointers/occupancy)
//   push_i, dat_i     : write strobe and data
//   pop_i             : read strobe (ignored when empty)
//   full_o, vld_o     : occupancy == 2, occupancy != 0
//   dat_o             : entry at the read pointer
module dmux4way16_buf_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [15:0] dat_i,
  output logic        full_o,
  output logic        vld_o,
  output logic [15:0] dat_o
);
  logic [15:0] mem_q [2];
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [1:0]  occ_q, occ_d;
  logic        do_push, do_pop;

  // Push is judged on the occupancy before this edge's pop, so a full FIFO
  // never accepts a word even when it drains in the same cycle.
  assign do_push = push_i && (occ_q != 2'd2);
  assign do_pop  = pop_i  && (occ_q != 2'd0);

  always_comb begin
    wptr_d = wptr_q ^ do_push;
    rptr_d = rptr_q ^ do_pop;
    occ_d  = occ_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  // Storage is not cleared; stale entries are unreachable once occupancy is 0.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_q[wptr_q] <= dat_i;
    end
  end

  assign full_o = (occ_q == 2'd2);
  assign vld_o  = (occ_q != 2'd0);
  assign dat_o  = mem_q[rptr_q];
endmodule

// Purpose: 1-to-4 demux of a 16-bit valid/ready stream into four buffered channels.
// Latency: 1 cycle, zero bubble; per-channel 2-deep FIFO sustains one word per cycle.
// Backpressure: entrada_ready drops only when the selected channel is full; others unaffected.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : upstream push port, four downstream channels, contador_total
module dmux4way16_buf (
  input  logic             clk,
  input  logic             reset,
  dmux4way16_buf_if.slave  bus
);
  logic [3:0]  ch_full;
  logic [3:0]  ch_vld;
  logic [3:0]  ch_push;
  logic [3:0]  ch_pop;
  logic [3:0]  ch_rdy;
  logic [15:0] ch_dat [4];
  logic [15:0] cnt_q, cnt_d;

  assign ch_rdy = {bus.saida_ready_d, bus.saida_ready_c,
                   bus.saida_ready_b, bus.saida_ready_a};

  // Depends only on the addressed channel's fullness, never on valid or
  // any downstream ready, so a changing sel re-evaluates it immediately.
  assign bus.entrada_ready = !reset && !ch_full[bus.entrada_sel];

  always_comb begin
    ch_push = 4'b0000;
    ch_push[bus.entrada_sel] = bus.entrada_valid && bus.entrada_ready;
  end

  assign ch_pop = ch_vld & ch_rdy;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    dmux4way16_buf_fifo u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_i (ch_push[g]),
      .pop_i  (ch_pop[g]),
      .dat_i  (bus.entrada_dado),
      .full_o (ch_full[g]),
      .vld_o  (ch_vld[g]),
      .dat_o  (ch_dat[g])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    if (|ch_push) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.saida_valid_a  = ch_vld[0];
  assign bus.saida_valid_b  = ch_vld[1];
  assign bus.saida_valid_c  = ch_vld[2];
  assign bus.saida_valid_d  = ch_vld[3];
  assign bus.saida_dado_a   = ch_dat[0];
  assign bus.saida_dado_b   = ch_dat[1];
  assign bus.saida_dado_c   = ch_dat[2];
  assign bus.saida_dado_d   = ch_dat[3];
  assign bus.contador_total = cnt_q;
endmodule

// File: tb/tb_dmux4way16_buf.sv
// Bench for dmux4way16_buf: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_dmux4way16_buf;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmux4way16_buf_if bus ();

  dmux4way16_buf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per channel, plus the accepted-word count.
  logic [15:0] mq [4][$];
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic get_vld(input int c);
    case (c)
      0:       return bus.saida_valid_a;
      1:       return bus.saida_valid_b;
      2:       return bus.saida_valid_c;
      default: return bus.saida_valid_d;
    endcase
  endfunction

  function automatic logic [15:0] get_dat(input int c);
    case (c)
      0:       return bus.saida_dado_a;
      1:       return bus.saida_dado_b;
      2:       return bus.saida_dado_c;
      default: return bus.saida_dado_d;
    endcase
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] d,
                       input logic [1:0] s, input logic [3:0] rd);
    reset             = r;
    bus.entrada_valid = v;
    bus.entrada_dado  = d;
    bus.entrada_sel   = s;
    bus.saida_ready_a = rd[0];
    bus.saida_ready_b = rd[1];
    bus.saida_ready_c = rd[2];
    bus.saida_ready_d = rd[3];
  endtask

  // One clock cycle: drive on the falling edge, compare all outputs against
  // the model, then advance the model to what the next rising edge produces.
  task automatic cyc(input logic r, input logic v, input logic [15:0] d,
                     input logic [1:0] s, input logic [3:0] rd);
    bit exp_rdy;
    int sel;
    @(negedge clk);
    drive(r, v, d, s, rd);
    #1;
    sel     = int'(s);
    exp_rdy = !r && (mq[sel].size() < 2);
    chk("entrada_ready", 32'(bus.entrada_ready), 32'(exp_rdy));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("saida_valid_%0d", c), 32'(get_vld(c)), 32'(mq[c].size() != 0));
      if (mq[c].size() != 0)
        chk($sformatf("saida_dado_%0d", c), 32'(get_dat(c)), 32'(mq[c][0]));
    end
    chk("contador_total", 32'(bus.contador_total), 32'(m_cnt));
    if (r) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
      m_cnt = 16'd0;
    end else begin
      for (int c = 0; c < 4; c++)
        if (rd[c] && mq[c].size() != 0) void'(mq[c].pop_front());
      if (v && exp_rdy) begin
        mq[sel].push_back(d);
        m_cnt = m_cnt + 16'd1;
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0, 2'd0, 4'h0);
    repeat (2) @(posedge clk);

    // First cycle out of reset: empty, ready, counter zero.
    cyc(0, 0, 16'h0, 2'd0, 4'h0);

    // Single word to channel c.
    cyc(0, 1, 16'h1234, 2'd2, 4'h0);
    @(posedge clk); #1;
    chk("c_valid_after_push", 32'(bus.saida_valid_c), 32'd1);
    chk("c_dado_after_push", 32'(bus.saida_dado_c), 32'h1234);
    chk("a_valid_idle", 32'(bus.saida_valid_a), 32'd0);
    chk("cnt_after_one", 32'(bus.contador_total), 32'd1);
    cyc(0, 0, 16'h0, 2'd0, 4'b0100);

    // Fill a, third push to a blocked, d still accepted, then a drains in order.
    cyc(0, 1, 16'hAAAA, 2'd0, 4'h0);
    cyc(0, 1, 16'hBBBB, 2'd0, 4'h0);
    cyc(0, 1, 16'hCCCC, 2'd0, 4'h0);
    chk("a_full_ready", 32'(bus.entrada_ready), 32'd0);
    cyc(0, 1, 16'hDDDD, 2'd3, 4'h0);
    chk("d_ready_while_a_full", 32'(bus.entrada_ready), 32'd1);
    cyc(0, 0, 16'h0, 2'd0, 4'b0001);
    chk("a_first_out", 32'(bus.saida_dado_a), 32'hAAAA);
    cyc(0, 0, 16'h0, 2'd0, 4'b0001);
    chk("a_second_out", 32'(bus.saida_dado_a), 32'hBBBB);
    cyc(0, 0, 16'h0, 2'd0, 4'b1000);

    // Simultaneous push and pop on b at occupancy 1.
    cyc(0, 1, 16'h0001, 2'd1, 4'h0);
    cyc(0, 1, 16'h0002, 2'd1, 4'b0010);
    chk("b_head_before", 32'(bus.saida_dado_b), 32'h0001);
    @(posedge clk); #1;
    chk("b_valid_after_swap", 32'(bus.saida_valid_b), 32'd1);
    chk("b_head_after_swap", 32'(bus.saida_dado_b), 32'h0002);
    cyc(0, 0, 16'h0, 2'd0, 4'b0010);
    chk("b_single_left", 32'(bus.saida_valid_b), 32'd1);
    cyc(0, 0, 16'h0, 2'd0, 4'b0000);

    // Full c popping still refuses a push that edge; accepts on the next.
    cyc(0, 1, 16'hC001, 2'd2, 4'h0);
    cyc(0, 1, 16'hC002, 2'd2, 4'h0);
    cyc(0, 1, 16'hC003, 2'd2, 4'b0100);
    chk("c_full_pop_ready", 32'(bus.entrada_ready), 32'd0);
    cyc(0, 1, 16'hC003, 2'd2, 4'b0100);
    chk("c_after_pop_ready", 32'(bus.entrada_ready), 32'd1);
    cyc(0, 0, 16'h0, 2'd0, 4'b0100);
    cyc(0, 0, 16'h0, 2'd0, 4'b0100);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), 1'($urandom), 16'($urandom),
          2'($urandom), 4'($urandom));
    end

    // Fill a and d, reset mid-operation, confirm nothing old comes back.
    cyc(0, 1, 16'h0A01, 2'd0, 4'h0);
    cyc(0, 1, 16'h0A02, 2'd0, 4'h0);
    cyc(0, 1, 16'h0D01, 2'd3, 4'h0);
    cyc(0, 1, 16'h0D02, 2'd3, 4'h0);
    cyc(1, 0, 16'h0, 2'd0, 4'h0);
    cyc(0, 0, 16'h0, 2'd0, 4'hF);
    chk("rst_a_valid", 32'(bus.saida_valid_a), 32'd0);
    chk("rst_d_valid", 32'(bus.saida_valid_d), 32'd0);
    chk("rst_cnt", 32'(bus.contador_total), 32'd0);
    chk("rst_ready", 32'(bus.entrada_ready), 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 2'($urandom), 4'hF);

    // Counter wrap: 65536 accepted pushes with every channel draining.
    cyc(1, 0, 16'h0, 2'd0, 4'h0);
    for (int i = 0; i < 65536; i++) begin
      cyc(0, 1, 16'($urandom), 2'($urandom), 4'hF);
    end
    @(posedge clk); #1;
    chk("cnt_wrap", 32'(bus.contador_total), 32'd0);
    cyc(0, 0, 16'h0, 2'd0, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
